// File: rtl/tagged_array_reader_if.sv
// Write port and buffered read request/response bus of the tag-labelled array reader.
interface tagged_array_reader_if #(
  parameter int DW = 3,
  parameter int CW = 8
);
  logic          wr_en;
  logic [3:0]    wr_idx;
  logic          wr_tag;
  logic [DW-1:0] wr_data;
  logic          rd_req;
  logic [3:0]    rd_idx;
  logic          rd_ready;
  logic          rd_ack;
  logic          rd_low_valid;
  logic [DW-1:0] rd_low_data;
  logic          rd_high_valid;
  logic [DW-1:0] rd_high_data;
  logic [CW-1:0] rd_high_cnt;

  modport master (
    output wr_en, wr_idx, wr_tag, wr_data, rd_req, rd_idx, rd_ack,
    input  rd_ready, rd_low_valid, rd_low_data, rd_high_valid, rd_high_data, rd_high_cnt
  );

  modport slave (
    input  wr_en, wr_idx, wr_tag, wr_data, rd_req, rd_idx, rd_ack,
    output rd_ready, rd_low_valid, rd_low_data, rd_high_valid, rd_high_data, rd_high_cnt
  );
endinterface

// File: rtl/tagged_array_reader.sv
// 16-entry tagged array with a one-deep read response buffer; responses are steered
// to the low or high port by the captured entry tag.
module tagged_array_reader #(
  parameter int ENTRIES = 16,
  parameter int DW      = 3,
  parameter int CW      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  tagged_array_reader_if.slave  bus
);
  typedef enum logic {EMPTY, FULL} state_t;

  logic          tags_reg [ENTRIES];
  logic [DW-1:0] data_reg [ENTRIES];

  state_t        state_reg, state_next;
  logic          buf_tag_reg, buf_tag_next;
  logic [DW-1:0] buf_data_reg, buf_data_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          ready;
  logic          accept;

  // Tag and data are always written as a pair so an entry never holds a mixed label.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        tags_reg[i] <= 1'b0;
        data_reg[i] <= '0;
      end
    end else if (bus.wr_en) begin
      tags_reg[bus.wr_idx] <= bus.wr_tag;
      data_reg[bus.wr_idx] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= EMPTY;
      buf_tag_reg  <= 1'b0;
      buf_data_reg <= '0;
      cnt_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      buf_tag_reg  <= buf_tag_next;
      buf_data_reg <= buf_data_next;
      cnt_reg      <= cnt_next;
    end
  end

  // Capture reads the pre-write array contents, so a same-cycle write is never seen.
  always_comb begin
    state_next    = state_reg;
    buf_tag_next  = buf_tag_reg;
    buf_data_next = buf_data_reg;
    cnt_next      = cnt_reg;
    ready         = 1'b1;
    case (state_reg)
      EMPTY:   ready = 1'b1;
      FULL:    ready = bus.rd_ack;
      default: ready = 1'b1;
    endcase
    accept = bus.rd_req & ready;
    if (accept) begin
      state_next    = FULL;
      buf_tag_next  = tags_reg[bus.rd_idx];
      buf_data_next = data_reg[bus.rd_idx];
      if (tags_reg[bus.rd_idx] && (cnt_reg != {CW{1'b1}}))
        cnt_next = cnt_reg + CW'(1);
    end else if ((state_reg == FULL) && bus.rd_ack) begin
      state_next = EMPTY;
    end
  end

  // Valids depend only on state and tag; data ports are zeroed when their valid is low.
  assign bus.rd_ready      = ready;
  assign bus.rd_low_valid  = (state_reg == FULL) && !buf_tag_reg;
  assign bus.rd_high_valid = (state_reg == FULL) &&  buf_tag_reg;
  assign bus.rd_low_data   = bus.rd_low_valid  ? buf_data_reg : '0;
  assign bus.rd_high_data  = bus.rd_high_valid ? buf_data_reg : '0;
  assign bus.rd_high_cnt   = cnt_reg;
endmodule

// File: tb/tb_tagged_array_reader.sv
// Directed plus randomized checks of tagged_array_reader against a queue-based model.
module tb_tagged_array_reader;
  localparam int DW = 3;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tagged_array_reader_if #(.DW(DW), .CW(CW)) bus_if ();
  tagged_array_reader #(.ENTRIES(16), .DW(DW), .CW(CW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus_if)
  );

  typedef struct { bit tag; int data; } resp_t;

  int    compared   = 0;
  int    mismatched = 0;
  bit    m_tag  [16];
  int    m_data [16];
  resp_t m_q [$];
  int    m_cnt;
  int    txn = 0;

  task automatic check(input string name, input logic [31:0] obs, input int exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d (txn %0d)", name, obs, exp, txn);
    end
  endtask

  task automatic step(input bit we, input int wi, input bit wt, input int wd,
                      input bit rq, input int ri, input bit ak, input bit rn);
    bit    rdy;
    resp_t r;
    bus_if.wr_en   = we;
    bus_if.wr_idx  = wi[3:0];
    bus_if.wr_tag  = wt;
    bus_if.wr_data = wd[DW-1:0];
    bus_if.rd_req  = rq;
    bus_if.rd_idx  = ri[3:0];
    bus_if.rd_ack  = ak;
    rst_n          = rn;
    rdy = (m_q.size() == 0) || ak;
    #1;
    if (rn) check("rd_ready", {31'b0, bus_if.rd_ready}, rdy ? 1 : 0);
    @(posedge clk);
    if (!rn) begin
      for (int i = 0; i < 16; i++) begin
        m_tag[i]  = 1'b0;
        m_data[i] = 0;
      end
      m_q.delete();
      m_cnt = 0;
    end else begin
      if (ak && m_q.size() != 0) void'(m_q.pop_front());
      if (rq && rdy) begin
        r.tag  = m_tag[ri];
        r.data = m_data[ri];
        m_q.push_back(r);
        if (r.tag && m_cnt < (1 << CW) - 1) m_cnt++;
      end
      if (we) begin
        m_tag[wi]  = wt;
        m_data[wi] = wd;
      end
    end
    #1;
    txn++;
    if (m_q.size() == 0) begin
      check("low_valid",  {31'b0, bus_if.rd_low_valid},  0);
      check("high_valid", {31'b0, bus_if.rd_high_valid}, 0);
      check("low_data",   {29'b0, bus_if.rd_low_data},   0);
      check("high_data",  {29'b0, bus_if.rd_high_data},  0);
    end else begin
      check("low_valid",  {31'b0, bus_if.rd_low_valid},  m_q[0].tag ? 0 : 1);
      check("high_valid", {31'b0, bus_if.rd_high_valid}, m_q[0].tag ? 1 : 0);
      check("low_data",   {29'b0, bus_if.rd_low_data},   m_q[0].tag ? 0 : m_q[0].data);
      check("high_data",  {29'b0, bus_if.rd_high_data},  m_q[0].tag ? m_q[0].data : 0);
    end
    check("high_cnt", {24'b0, bus_if.rd_high_cnt}, m_cnt);
    $display("txn %0d rst_n=%0b wr=%0b/%0d/%0b/%0d rd=%0b/%0d ack=%0b -> lo=%0b:%0d hi=%0b:%0d cnt=%0d",
             txn, rn, we, wi, wt, wd, rq, ri, ak, bus_if.rd_low_valid, bus_if.rd_low_data,
             bus_if.rd_high_valid, bus_if.rd_high_data, bus_if.rd_high_cnt);
  endtask

  initial begin
    // Reset, then idle cycle checks ready=1 and empty outputs.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Low entry write and read.
    step(1, 3, 0, 5, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 3, 0, 1);
    check("dir_low_data", {29'b0, bus_if.rd_low_data}, 5);
    step(0, 0, 0, 0, 0, 0, 1, 1);

    // High entry write and read.
    step(1, 7, 1, 6, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1, 7, 0, 1);
    check("dir_high_data", {29'b0, bus_if.rd_high_data}, 6);
    check("dir_cnt1", {24'b0, bus_if.rd_high_cnt}, 1);
    step(0, 0, 0, 0, 0, 0, 1, 1);

    // Backpressure: hold buffer for 4 cycles, then ack with a new request.
    step(0, 0, 0, 0, 1, 3, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 7, 0, 1);
    step(0, 0, 0, 0, 1, 7, 1, 1);
    check("dir_bp_high", {29'b0, bus_if.rd_high_data}, 6);

    // Same-cycle write and read of idx 7 sees the old pair.
    step(1, 7, 0, 2, 1, 7, 1, 1);
    check("dir_prewrite", {29'b0, bus_if.rd_high_data}, 6);
    step(0, 0, 0, 0, 1, 7, 1, 1);
    check("dir_postwrite", {29'b0, bus_if.rd_low_data}, 2);
    step(0, 0, 0, 0, 0, 0, 1, 1);

    // Saturation with full throughput.
    step(1, 7, 1, 6, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) step(0, 0, 0, 0, 1, 7, 1, 1);
    check("dir_sat", {24'b0, bus_if.rd_high_cnt}, 255);

    // Reset while FULL.
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 7, 0, 1);
    check("dir_rst_read", {29'b0, bus_if.rd_low_data}, 0);
    step(0, 0, 0, 0, 0, 0, 1, 1);

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 1), $urandom_range(0, 7),
           $urandom_range(0, 3) != 0, $urandom_range(0, 15), $urandom_range(0, 2) != 0,
           $urandom_range(0, 59) != 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
